// File: rtl/single_pkg.sv
// Constants and state type shared by the single-precision arithmetic blocks.
package single_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    PACK
  } state_e;

endpackage

// File: rtl/single_divide_if.sv
// Operand/result handshake bundle for single_divide.
interface single_divide_if;

  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] c;
  logic        div_by_zero;

  modport master (
    output in_valid, a, b,
    input  in_ready, out_valid, c, div_by_zero
  );

  modport slave (
    input  in_valid, a, b,
    output in_ready, out_valid, c, div_by_zero
  );

endinterface

// File: rtl/single_div_core.sv
// 24-step restoring divider for normalised mantissas, one quotient bit per cycle, MSB first.
// Only the 23 fraction bits are kept because the leading quotient bit is always 1.
module single_div_core
  import single_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [MAN_W:0]   ma_i,
  input  logic [MAN_W:0]   mb_i,
  output logic             done_o,
  output logic [MAN_W-1:0] quotient_o
);

  localparam logic [4:0] LAST_STEP = 5'(MAN_W);

  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W:0]   div_q, div_d;
  logic [MAN_W:0]   diff;
  logic [MAN_W-1:0] quot_q, quot_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    // Only meaningful when rem >= divisor, where the true difference fits in 24 bits.
    diff   = rem_q[MAN_W:0] - div_q;
    if (start_i) begin
      rem_d  = (ma_i < mb_i) ? {ma_i, 1'b0} : {1'b0, ma_i};
      div_d  = mb_i;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_q >= {1'b0, div_q}) begin
        quot_d = {quot_q[MAN_W-2:0], 1'b1};
        rem_d  = {diff, 1'b0};
      end else begin
        quot_d = {quot_q[MAN_W-2:0], 1'b0};
        rem_d  = {rem_q[MAN_W:0], 1'b0};
      end
      cnt_d  = cnt_q + 5'd1;
      busy_d = (cnt_q != LAST_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // High during the final step; quotient_o is complete from the following cycle.
  assign done_o     = busy_q && (cnt_q == LAST_STEP);
  assign quotient_o = quot_q;

endmodule

// File: rtl/single_divide.sv
// Fixed-latency IEEE-754 single-precision divider: truncating, denormals flushed, no NaN output.
// The FSM here owns exponent, sign and special cases; the mantissa loop lives in single_div_core.
module single_divide
  import single_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  single_divide_if.slave bus
);

  localparam logic        [EXP_W+1:0] BIAS_X  = BIAS[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] EMAX_S  = EXP_MAX[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] EZERO_S = '0;

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic             dbz_q, dbz_d, ov_q, ov_d;
  logic [MAN_W:0]   ma, mb;
  logic [EXP_W-1:0] ea, eb;
  logic             sign, a_zero, b_zero, adj;
  logic [EXP_W+1:0] exp_u;
  logic signed [EXP_W+1:0] exp_s;
  logic [31:0]      res;
  logic             core_done;
  logic [MAN_W-1:0] quotient;

  assign ma = {1'b1, a_q[MAN_W-1:0]};
  assign mb = {1'b1, b_q[MAN_W-1:0]};
  assign ea = a_q[MAN_W +: EXP_W];
  assign eb = b_q[MAN_W +: EXP_W];

  single_div_core u_core (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (state_q == PREP),
    .ma_i       (ma),
    .mb_i       (mb),
    .done_o     (core_done),
    .quotient_o (quotient)
  );

  // Result packing; zero results are always +0, and a zero divisor wins over a zero dividend.
  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    adj    = (ma < mb);
    exp_u  = {2'b00, ea} - {2'b00, eb} + BIAS_X - {{(EXP_W+1){1'b0}}, adj};
    exp_s  = signed'(exp_u);
    res    = '0;
    if (b_zero)
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero)
      res = '0;
    else if (exp_s >= EMAX_S)
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp_s <= EZERO_S)
      res = '0;
    else
      res = {sign, exp_s[EXP_W-1:0], quotient};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    dbz_d   = dbz_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        state_d = PREP;
      end
      PREP: state_d = CALC;
      CALC: if (core_done) state_d = PACK;
      PACK: begin
        state_d = IDLE;
        ov_d    = 1'b1;
        c_d     = res;
        dbz_d   = b_zero;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = ov_q;
  assign bus.c           = c_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_single_divide.sv
// Directed and random stimulus for single_divide with a latency-aware scoreboard.
module tb_single_divide;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  single_divide_if bus ();

  single_divide dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] c;
    logic        dbz;
    int          outCycle;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        dbz;
  } vec_t;

  exp_t sbQ[$];
  exp_t monE;
  int   cycle      = 0;
  int   passCount  = 0;
  int   checkCount = 0;
  int   failCount  = 0;
  int   ovCount    = 0;

  vec_t dirVec [19] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0},
    '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0},
    '{32'h00000000, 32'hC0A00000, 32'h00000000, 1'b0},
    '{32'h40A00000, 32'h80000000, 32'hFF800000, 1'b1},
    '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0},
    '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0},
    '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0},
    '{32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1},
    '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1},
    '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0},
    '{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0},
    '{32'h7FC00000, 32'h40000000, 32'h7F400000, 1'b0},
    '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0},
    '{32'h00800000, 32'h3FC00000, 32'h00000000, 1'b0},
    '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0},
    '{32'hFF000000, 32'h3F000000, 32'hFF800000, 1'b0},
    '{32'h80800000, 32'h7F000000, 32'h00000000, 1'b0},
    '{32'h80000000, 32'h3F800000, 32'h00000000, 1'b0}
  };

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Integer long division as an independent reference for the truncated quotient.
  function automatic void modelDivide(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] c, output logic dbz);
    logic   sign;
    int     ea, eb, e;
    longint ma, mb, q;
    sign = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    dbz  = 1'b0;
    c    = 32'h0;
    if (eb == 0) begin
      c   = {sign, 8'hFF, 23'h0};
      dbz = 1'b1;
    end else if (ea != 0) begin
      ma = 64'h800000 | 64'(a[22:0]);
      mb = 64'h800000 | 64'(b[22:0]);
      e  = ea - eb + 127;
      if (ma < mb) begin
        ma = ma * 2;
        e  = e - 1;
      end
      q = (ma << 23) / mb;
      if (e >= 255)
        c = {sign, 8'hFF, 23'h0};
      else if (e > 0)
        c = {sign, e[7:0], q[22:0]};
    end
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ovCount++;
      if (sbQ.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(bus.out_valid), 32'h0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput($sformatf("c@%0d", monE.outCycle), bus.c, monE.c);
        checkOutput($sformatf("div_by_zero@%0d", monE.outCycle), 32'(bus.div_by_zero), 32'(monE.dbz));
        checkOutput("latency_cycle", cycle, monE.outCycle);
        checkOutput("in_ready_with_out_valid", 32'(bus.in_ready), 32'h1);
      end
    end
  end

  // Called at #1 after an edge with the DUT idle; the result is due 26 edges after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expC, input logic expDbz);
    exp_t e;
    checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'h1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    e.c          = expC;
    e.dbz        = expDbz;
    e.outCycle   = cycle + 27;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic drainQueue(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 32'(sbQ.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, rc;
    logic        rd;
    int          acc;
    int          ovBase;

    bus.in_valid = 1'b0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    rstn         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_c", bus.c, 32'h0);
    checkOutput("reset_div_by_zero", 32'(bus.div_by_zero), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(dirVec[i].a, dirVec[i].b, dirVec[i].c, dirVec[i].dbz);
      drainQueue(40);
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 4) begin
        ra[30:23] = 8'($urandom_range(190, 60));
        rb[30:23] = 8'($urandom_range(190, 60));
      end
      modelDivide(ra, rb, rc, rd);
      applyStimulus(ra, rb, rc, rd);
      drainQueue(40);
    end

    $display("[TB] busy strobe and back-to-back accept");
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    acc = cycle;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("in_ready_while_busy", 32'(bus.in_ready), 32'h0);
    bus.a        = 32'h3F800000;
    bus.b        = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    while (cycle < acc + 26) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0);
    drainQueue(40);

    $display("[TB] reset mid-operation");
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc          = cycle;
    bus.in_valid = 1'b0;
    while (cycle < acc + 9) begin
      @(posedge clk);
      #1;
    end
    rstn         = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rstn         = 1'b1;
    bus.in_valid = 1'b0;
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("post_reset_c", bus.c, 32'h0);
    checkOutput("post_reset_div_by_zero", 32'(bus.div_by_zero), 32'h0);
    checkOutput("post_reset_out_valid", 32'(bus.out_valid), 32'h0);
    ovBase = ovCount;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("out_valid_count_after_reset", 32'(ovCount - ovBase), 32'h0);
    checkOutput("idle_after_reset_window", 32'(bus.in_ready), 32'h1);

    drainQueue(40);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
